// File: rtl/fib_pkg.sv
// Shared constants and controller state encodings for the Fibonacci lab.
// Imported by the datapath, its counter and the controller-side bench.
package fib_pkg;

    localparam int unsigned FIB_WIDTH    = 16;
    localparam int unsigned FIB_CWIDTH   = 6;
    // Largest index whose Fibonacci value fits in 16 bits
    localparam int unsigned FIB_MAX_N_16 = 24;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSum   = 2'd1,
        StShift = 2'd2,
        StCheck = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fib_down_counter.sv
// Loadable iteration counter for the Fibonacci datapath.
// Decrements only while non-zero, so it saturates at 0.
module fib_down_counter
    import fib_pkg::*;
#(
    parameter int unsigned CWIDTH = FIB_CWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              decr_i,
    input  logic [CWIDTH-1:0] load_value_i,
    output logic [CWIDTH-1:0] count_o,
    output logic              zero_o
);

    logic [CWIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (decr_i && (count_q != '0)) begin
            count_d = count_q - CWIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/fib_datapath.sv
// Strobe-driven Fibonacci datapath: operand registers A/B, sum S, counter C.
// Each register carries an overflow tag so only a wrapped A raises overflow.
module fib_datapath
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH  = FIB_WIDTH,
    parameter int unsigned CWIDTH = FIB_CWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_regs,
    input  logic              add_regs,
    input  logic              shift_regs,
    input  logic              decr_c,
    input  logic [CWIDTH-1:0] n_in,
    output logic              zero,
    output logic [WIDTH-1:0]  result,
    output logic              overflow
);

    logic [WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
    logic             ao_d, ao_q, bo_d, bo_q, so_d, so_q;
    logic [WIDTH:0]   sum_full;
    logic [CWIDTH-1:0] c_count;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};

    // load overrides everything; add and shift both read pre-edge values
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        s_d  = s_q;
        ao_d = ao_q;
        bo_d = bo_q;
        so_d = so_q;
        if (load_regs) begin
            a_d  = '0;
            b_d  = WIDTH'(1);
            s_d  = '0;
            ao_d = 1'b0;
            bo_d = 1'b0;
            so_d = 1'b0;
        end else begin
            if (add_regs) begin
                s_d  = sum_full[WIDTH-1:0];
                so_d = sum_full[WIDTH] | ao_q | bo_q;
            end
            if (shift_regs) begin
                a_d  = b_q;
                b_d  = s_q;
                ao_d = bo_q;
                bo_d = so_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
            ao_q <= 1'b0;
            bo_q <= 1'b0;
            so_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            s_q  <= s_d;
            ao_q <= ao_d;
            bo_q <= bo_d;
            so_q <= so_d;
        end
    end

    fib_down_counter #(
        .CWIDTH(CWIDTH)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .load_i       (load_regs),
        .decr_i       (decr_c & ~load_regs),
        .load_value_i (n_in),
        .count_o      (c_count),
        .zero_o       (zero)
    );

    assign result   = a_q;
    assign overflow = ao_q;

endmodule

// File: tb/tb_fib_datapath.sv
// Directed bench for fib_datapath; emulates the lab controller with strobe sequences.
module tb_fib_datapath;
    import fib_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  load_regs = 1'b0;
    logic                  add_regs = 1'b0;
    logic                  shift_regs = 1'b0;
    logic                  decr_c = 1'b0;
    logic [FIB_CWIDTH-1:0] n_in = '0;
    logic                  zero;
    logic [FIB_WIDTH-1:0]  result;
    logic                  overflow;

    int checks = 0;
    int errors = 0;
    int cyc;

    fib_datapath #(
        .WIDTH  (FIB_WIDTH),
        .CWIDTH (FIB_CWIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_regs  (load_regs),
        .add_regs   (add_regs),
        .shift_regs (shift_regs),
        .decr_c     (decr_c),
        .n_in       (n_in),
        .zero       (zero),
        .result     (result),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic iterate();
        add_regs = 1'b1;
        tick();
        add_regs   = 1'b0;
        shift_regs = 1'b1;
        decr_c     = 1'b1;
        tick();
        shift_regs = 1'b0;
        decr_c     = 1'b0;
        tick();
    endtask

    // Controller model: load, then sum / shift+decr / check until zero
    task automatic run_fib(input int n, output int cycles);
        fib_state_e st;
        int guard;
        n_in      = FIB_CWIDTH'(n);
        load_regs = 1'b1;
        tick();
        load_regs = 1'b0;
        cycles = 1;
        guard  = 0;
        st     = StSum;
        while (st != StIdle && guard < 400) begin
            case (st)
                StSum: begin
                    add_regs = 1'b1;
                    tick();
                    add_regs = 1'b0;
                    st = StShift;
                end
                StShift: begin
                    shift_regs = 1'b1;
                    decr_c     = 1'b1;
                    tick();
                    shift_regs = 1'b0;
                    decr_c     = 1'b0;
                    st = StCheck;
                end
                default: begin
                    st = zero ? StIdle : StSum;
                    tick();
                end
            endcase
            cycles++;
            guard++;
        end
        check("run_bound", 32'(st == StIdle), 32'd1);
    endtask

    initial begin
        #2;
        check("reset_result", 32'(result), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        #10;
        reset = 1'b0;
        tick();

        // Mid-run async reset after three iterations of n=10
        n_in      = 6'd10;
        load_regs = 1'b1;
        tick();
        load_regs = 1'b0;
        for (int i = 0; i < 3; i++) iterate();
        check("mid_result", 32'(result), 32'd2);
        check("mid_zero", 32'(zero), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_result", 32'(result), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_zero", 32'(zero), 32'd1);
        #1;
        reset = 1'b0;
        tick();
        run_fib(5, cyc);
        check("n5_result", 32'(result), 32'd5);
        check("n5_cycles", 32'(cyc), 32'd16);

        run_fib(10, cyc);
        check("n10_cycles", 32'(cyc), 32'd31);
        check("n10_result", 32'(result), 32'd55);
        check("n10_overflow", 32'(overflow), 32'd0);
        check("n10_zero", 32'(zero), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("n10_hold", 32'(result), 32'd55);

        run_fib(1, cyc);
        check("n1_result", 32'(result), 32'd1);
        check("n1_cycles", 32'(cyc), 32'd4);

        run_fib(0, cyc);
        check("n0_result", 32'(result), 32'd1);
        check("n0_cycles", 32'(cyc), 32'd4);
        check("n0_count", 32'(dut.c_count), 32'd0);
        decr_c = 1'b1;
        tick();
        decr_c = 1'b0;
        check("n0_no_wrap", 32'(dut.c_count), 32'd0);

        run_fib(24, cyc);
        check("n24_result", 32'(result), 32'd46368);
        check("n24_overflow", 32'(overflow), 32'd0);
        check("n24_s_wrapped", 32'(dut.s_q), 32'd9489);
        check("n24_so", 32'(dut.so_q), 32'd1);

        run_fib(25, cyc);
        check("n25_result", 32'(result), 32'd9489);
        check("n25_overflow", 32'(overflow), 32'd1);
        run_fib(3, cyc);
        check("n3_overflow", 32'(overflow), 32'd0);
        check("n3_result", 32'(result), 32'd2);

        // Direct strobes: add+shift+decr in one cycle; shift sees old S
        n_in      = 6'd4;
        load_regs = 1'b1;
        tick();
        load_regs  = 1'b0;
        add_regs   = 1'b1;
        shift_regs = 1'b1;
        decr_c     = 1'b1;
        tick();
        add_regs   = 1'b0;
        shift_regs = 1'b0;
        decr_c     = 1'b0;
        check("combo_a", 32'(result), 32'd1);
        check("combo_b", 32'(dut.b_q), 32'd0);
        check("combo_s", 32'(dut.s_q), 32'd1);
        check("combo_c", 32'(dut.c_count), 32'd3);

        // load beats add/shift/decr in the same cycle
        n_in       = 6'd7;
        load_regs  = 1'b1;
        add_regs   = 1'b1;
        shift_regs = 1'b1;
        decr_c     = 1'b1;
        tick();
        load_regs  = 1'b0;
        add_regs   = 1'b0;
        shift_regs = 1'b0;
        decr_c     = 1'b0;
        check("prio_s", 32'(dut.s_q), 32'd0);
        check("prio_c", 32'(dut.c_count), 32'd7);
        check("prio_a", 32'(result), 32'd0);
        check("prio_b", 32'(dut.b_q), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
